// File: rtl/gpio_capture_pkg.sv
// ---------------------------------------------------------------------------
// gpio_capture_pkg
//
// Shared constants and event record types for the GPIO input capture block.
//   NPADS_DEFAULT : number of monitored pads (OPENFRAME_IO_PADS)
//   PIN_W         : width of an event's pin index field
//   TS_W_DEFAULT  : default timestamp width
//   evt_tag_t     : pin index + edge polarity of one event
//   evt_rec_t     : full event record (pin, rising, timestamp) at the
//                   default timestamp width
// ---------------------------------------------------------------------------
package gpio_capture_pkg;

    localparam int NPADS_DEFAULT = 44;
    localparam int PIN_W         = 6;
    localparam int TS_W_DEFAULT  = 16;

    // Pin/polarity part of an event; this is what always travels through
    // the event FIFO, with or without a timestamp beside it.
    typedef struct packed {
        logic [PIN_W-1:0] pin;
        logic             rising;
    } evt_tag_t;

    localparam int TAG_W = $bits(evt_tag_t);

    // Complete event record as seen by a consumer at the default width.
    typedef struct packed {
        logic [PIN_W-1:0]        pin;
        logic                    rising;
        logic [TS_W_DEFAULT-1:0] ts;
    } evt_rec_t;

endpackage

// File: rtl/gpio_capture_fifo.sv
// ---------------------------------------------------------------------------
// gpio_capture_fifo
//
// Small first-word-fall-through event FIFO with simultaneous push/pop.
// The storage is a register array read combinationally at the read
// pointer, so the head entry is visible in the cycle after it is written.
//
// Parameters
//   DEPTH : number of entries, power of two, >= 2
//   WIDTH : entry width in bits
// Ports
//   clk        : clock
//   reset      : synchronous active-high reset (empties the FIFO)
//   push       : write push_data this cycle (ignored when no room)
//   push_data  : entry to write
//   pop_valid  : head entry is valid
//   pop_ready  : consumer takes the head entry this cycle
//   pop_data   : head entry
//   count      : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module gpio_capture_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign pop_valid = (count_reg != '0);
    assign do_pop    = pop_valid & pop_ready;
    // A full FIFO still takes a write when the head leaves in the same
    // cycle: the freed slot is the one the write pointer already points at.
    assign do_push   = push & ((count_reg < CNT_W'(DEPTH)) | do_pop);
    assign pop_data  = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/gpio_in_capture.sv
// ---------------------------------------------------------------------------
// gpio_in_capture
//
// Synchronises the GPIO pad inputs, detects enabled rising/falling edges,
// latches them as per-pin pending bits and serialises the pending bits into
// an event FIFO (lowest pin first, rise before fall within a pin).
//
// Build option
//   GPIO_CAPTURE_TIMESTAMP_EN : when defined, a free-running TS_W counter is
//   stored with each event and presented on evt_time. When undefined, the
//   counter and timestamp storage are absent and evt_time is 0.
//
// Parameters
//   NPADS      : number of pads monitored (<= 64)
//   FIFO_DEPTH : event FIFO depth, power of two, >= 2
//   TS_W       : timestamp width
// Ports
//   clk        : clock
//   reset      : synchronous active-high reset
//   gpio_in    : asynchronous pad levels
//   rise_en    : per-pin rising-edge enable
//   fall_en    : per-pin falling-edge enable
//   gpio_sync  : synchronised pad levels
//   evt_valid  : head event valid
//   evt_ready  : consumer accepts head event
//   evt_pin    : head event pin index
//   evt_rising : head event polarity (1 = rising)
//   evt_time   : head event timestamp
//   overflow   : sticky lost-event flag
//   ovf_clr    : clears overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module gpio_in_capture
    import gpio_capture_pkg::*;
#(
    parameter int NPADS      = NPADS_DEFAULT,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NPADS-1:0] gpio_in,
    input  logic [NPADS-1:0] rise_en,
    input  logic [NPADS-1:0] fall_en,
    output logic [NPADS-1:0] gpio_sync,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [PIN_W-1:0] evt_pin,
    output logic             evt_rising,
    output logic [TS_W-1:0]  evt_time,
    output logic             overflow,
    input  logic             ovf_clr
);

    // Pending bits are arbitrated as one vector of 2*NPADS slots:
    // slot 2*i is pin i rising, slot 2*i+1 is pin i falling, so the lowest
    // set slot is automatically "lowest pin, rise before fall".
    localparam int NSLOT  = 2 * NPADS;
    localparam int SLOT_W = $clog2(NSLOT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

`ifdef GPIO_CAPTURE_TIMESTAMP_EN
    localparam int EVT_W = TAG_W + TS_W;
`else
    localparam int EVT_W = TAG_W;
`endif

    // ------------------------------------------------------------------
    // Synchroniser, edge history and post-reset arming
    // ------------------------------------------------------------------
    logic [NPADS-1:0] sync1_reg;
    logic [NPADS-1:0] sync2_reg;
    logic [NPADS-1:0] sync3_reg;
    logic [1:0]       arm_cnt_reg;
    logic             armed;

    // The first cycles after reset compare a freshly loaded sync2 against a
    // reset-zero sync3; holding detection off until the chain has filled
    // keeps pins that were already high from looking like rising edges.
    assign armed     = (arm_cnt_reg == 2'd3);
    assign gpio_sync = sync2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg   <= '0;
            sync2_reg   <= '0;
            sync3_reg   <= '0;
            arm_cnt_reg <= '0;
        end else begin
            sync1_reg <= gpio_in;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
            if (!armed) begin
                arm_cnt_reg <= arm_cnt_reg + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detection and pending bits
    // ------------------------------------------------------------------
    logic [NPADS-1:0] rise_det;
    logic [NPADS-1:0] fall_det;
    logic [NPADS-1:0] pend_rise_reg;
    logic [NPADS-1:0] pend_fall_reg;
    logic [NPADS-1:0] pend_rise_next;
    logic [NPADS-1:0] pend_fall_next;
    logic [NPADS-1:0] drop_vec;
    logic [NSLOT-1:0] pend_vec;
    logic [NSLOT-1:0] grant;
    logic [NSLOT-1:0] push_grant;
    logic             do_push;

    genvar gi;
    generate
        for (gi = 0; gi < NPADS; gi++) begin : g_pin
            assign rise_det[gi] = armed & sync2_reg[gi] & ~sync3_reg[gi] & rise_en[gi];
            assign fall_det[gi] = armed & ~sync2_reg[gi] & sync3_reg[gi] & fall_en[gi];

            assign pend_vec[2*gi]   = pend_rise_reg[gi];
            assign pend_vec[2*gi+1] = pend_fall_reg[gi];

            // An edge that finds its pending bit already set is lost, even if
            // that bit is being pushed this very cycle.
            assign drop_vec[gi] = (rise_det[gi] & pend_rise_reg[gi])
                                | (fall_det[gi] & pend_fall_reg[gi]);

            // The enables only gate new detections; an already pending bit
            // survives until it is pushed.
            assign pend_rise_next[gi] = (pend_rise_reg[gi] & ~push_grant[2*gi])
                                      | (rise_det[gi] & ~pend_rise_reg[gi]);
            assign pend_fall_next[gi] = (pend_fall_reg[gi] & ~push_grant[2*gi+1])
                                      | (fall_det[gi] & ~pend_fall_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_rise_reg <= '0;
            pend_fall_reg <= '0;
        end else begin
            pend_rise_reg <= pend_rise_next;
            pend_fall_reg <= pend_fall_next;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration: isolate the lowest set slot and encode its index
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0] slot_idx;
    logic [CNT_W-1:0]  fifo_count;
    logic              can_accept;
    evt_tag_t          push_tag;

    // x & -x keeps only the lowest set bit.
    assign grant = pend_vec & (~pend_vec + NSLOT'(1));

    always_comb begin
        slot_idx = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (grant[k]) begin
                slot_idx = slot_idx | SLOT_W'(k);
            end
        end
    end

    // Room exists below the depth, or at full depth when the head leaves
    // on this same edge.
    assign can_accept = (fifo_count < CNT_W'(FIFO_DEPTH)) | (evt_valid & evt_ready);
    assign do_push    = can_accept & (|pend_vec);
    assign push_grant = do_push ? grant : '0;

    assign push_tag.pin    = PIN_W'(slot_idx[SLOT_W-1:1]);
    assign push_tag.rising = ~slot_idx[0];

    // ------------------------------------------------------------------
    // Overflow flag: a drop in the same cycle as a clear keeps it set
    // ------------------------------------------------------------------
    logic overflow_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= (overflow_reg & ~ovf_clr) | (|drop_vec);
        end
    end

    assign overflow = overflow_reg;

    // ------------------------------------------------------------------
    // Event FIFO and optional timestamp
    // ------------------------------------------------------------------
    logic [EVT_W-1:0] fifo_wr_data;
    logic [EVT_W-1:0] fifo_rd_data;
    logic             fifo_valid;
    evt_tag_t         head_tag;
    logic [TS_W-1:0]  head_ts;

`ifdef GPIO_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_reg;

    // Free-running; wraps naturally from all-ones to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt_reg <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + TS_W'(1);
        end
    end

    assign fifo_wr_data = {push_tag, ts_cnt_reg};
    assign head_ts      = fifo_rd_data[TS_W-1:0];
`else
    assign fifo_wr_data = push_tag;
    assign head_ts      = '0;
`endif

    assign head_tag = evt_tag_t'(fifo_rd_data[EVT_W-1 -: TAG_W]);

    gpio_capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (do_push),
        .push_data (fifo_wr_data),
        .pop_valid (fifo_valid),
        .pop_ready (evt_ready),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count)
    );

    // Head fields read zero whenever nothing is queued, so unreset storage
    // never shows through (in particular during and just after reset).
    assign evt_valid  = fifo_valid;
    assign evt_pin    = fifo_valid ? head_tag.pin : '0;
    assign evt_rising = fifo_valid & head_tag.rising;
    assign evt_time   = fifo_valid ? head_ts : '0;

endmodule

// File: tb/tb_gpio_in_capture.sv
// ---------------------------------------------------------------------------
// tb_gpio_in_capture
//
// Directed bench for gpio_in_capture (NPADS=44, FIFO_DEPTH=8, TS_W=4).
// A behavioural model tracks sampled input history, pending events, the
// event queue, overflow and the timestamp; a compare process checks the DUT
// against it every cycle. Each scenario also pins the model with literal
// expectations. One line is printed per consumed event.
// ---------------------------------------------------------------------------
module tb_gpio_in_capture;

    localparam int NP    = 44;
    localparam int DEPTH = 8;
    localparam int TSW   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] gpio_in;
    logic [NP-1:0] rise_en;
    logic [NP-1:0] fall_en;
    logic [NP-1:0] gpio_sync;
    logic          evt_valid;
    logic          evt_ready;
    logic [5:0]    evt_pin;
    logic          evt_rising;
    logic [TSW-1:0] evt_time;
    logic          overflow;
    logic          ovf_clr;

    always #5 clk = ~clk;

    gpio_in_capture #(
        .NPADS      (NP),
        .FIFO_DEPTH (DEPTH),
        .TS_W       (TSW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gpio_in    (gpio_in),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .gpio_sync  (gpio_sync),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_pin    (evt_pin),
        .evt_rising (evt_rising),
        .evt_time   (evt_time),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- cycle counters ----------------
    int cyc     = 0;
    int n_edges = 0;   // clock edges seen with reset low since release
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        int pin;
        bit rising;
        int ts;
    } mevt_t;

    mevt_t         mq[$];
    logic [NP-1:0] seen [3];   // gpio_in as sampled 1, 2, 3 edges ago
    bit            m_pr [NP];
    bit            m_pf [NP];
    bit            new_r [NP];
    bit            new_f [NP];
    bit            m_ovf;
    int            m_ts;
    int            m_since;
    bit            m_live = 1'b0;
    bit            m_pop, m_accept, m_ovf_set, m_push_r;
    int            m_push_pin;
    mevt_t         m_e;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                for (int p = 0; p < NP; p++) begin
                    m_pr[p] = 1'b0;
                    m_pf[p] = 1'b0;
                end
                for (int k = 0; k < 3; k++) seen[k] = '0;
                m_ovf   = 1'b0;
                m_ts    = 0;
                m_since = 0;
            end else begin
                m_pop    = (mq.size() > 0) && evt_ready;
                m_accept = (mq.size() < DEPTH) || m_pop;
                m_push_pin = -1;
                m_push_r   = 1'b0;
                if (m_accept) begin
                    for (int p = 0; p < NP; p++) begin
                        if (m_push_pin < 0 && (m_pr[p] || m_pf[p])) begin
                            m_push_pin = p;
                            m_push_r   = m_pr[p];
                        end
                    end
                end
                m_ovf_set = 1'b0;
                for (int p = 0; p < NP; p++) begin
                    new_r[p] = 1'b0;
                    new_f[p] = 1'b0;
                    if (m_since >= 3) begin
                        if (rise_en[p] && seen[1][p] && !seen[2][p]) begin
                            if (m_pr[p]) m_ovf_set = 1'b1;
                            else         new_r[p]  = 1'b1;
                        end
                        if (fall_en[p] && !seen[1][p] && seen[2][p]) begin
                            if (m_pf[p]) m_ovf_set = 1'b1;
                            else         new_f[p]  = 1'b1;
                        end
                    end
                end
                if (m_pop) void'(mq.pop_front());
                if (m_push_pin >= 0) begin
                    m_e.pin    = m_push_pin;
                    m_e.rising = m_push_r;
`ifdef GPIO_CAPTURE_TIMESTAMP_EN
                    m_e.ts     = m_ts;
`else
                    m_e.ts     = 0;
`endif
                    mq.push_back(m_e);
                    if (m_push_r) m_pr[m_push_pin] = 1'b0;
                    else          m_pf[m_push_pin] = 1'b0;
                end
                for (int p = 0; p < NP; p++) begin
                    if (new_r[p]) m_pr[p] = 1'b1;
                    if (new_f[p]) m_pf[p] = 1'b1;
                end
                m_ovf   = (m_ovf && !ovf_clr) || m_ovf_set;
                m_ts    = (m_ts + 1) % (1 << TSW);
                seen[2] = seen[1];
                seen[1] = seen[0];
                seen[0] = gpio_in;
                m_since++;
            end
            m_live = 1'b1;
        end
    end

    // ---------------- per-cycle compare and event log ----------------
    typedef struct {
        int pin;
        bit rising;
        int ts;
        int cyc;
    } pop_t;

    pop_t pop_log[$];
    pop_t pl;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (m_live) begin
                check("model_gpio_sync", gpio_sync, seen[1]);
                check("model_evt_valid", evt_valid, (mq.size() > 0));
                if (mq.size() > 0) begin
                    check("model_evt_pin", evt_pin, mq[0].pin);
                    check("model_evt_rising", evt_rising, mq[0].rising);
                    check("model_evt_time", evt_time, mq[0].ts);
                end else begin
                    check("model_idle_pin", evt_pin, 0);
                    check("model_idle_time", evt_time, 0);
                end
                check("model_overflow", overflow, m_ovf);
            end
            if (evt_valid && evt_ready) begin
                pl.pin    = evt_pin;
                pl.rising = evt_rising;
                pl.ts     = evt_time;
                pl.cyc    = cyc;
                pop_log.push_back(pl);
                $display("event pin=%0d rising=%0d time=%0d cycle=%0d", pl.pin, pl.rising, pl.ts, pl.cyc);
            end
        end
    end

    // ---------------- timeout ----------------
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- directed scenarios ----------------
    int t40_pins [10] = '{12, 2, 30, 7, 1, 43, 20, 5, 9, 15};
    int guard;

    initial begin
        reset     = 1'b1;
        gpio_in   = '0;
        rise_en   = '0;
        rise_en[5] = 1'b1;
        fall_en   = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Reset state
        wait_neg(3);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_gpio_sync", gpio_sync, 0);
        check("rst_overflow", overflow, 0);
        check("rst_evt_pin", evt_pin, 0);
        check("rst_evt_time", evt_time, 0);

        // Single rise on pin 5: valid in the cycle after the third edge
        reset = 1'b0;
        wait_neg(6);
        gpio_in[5] = 1'b1;
        wait_neg(3);
        check("t37_valid_before_e3", evt_valid, 0);
        wait_neg(1);
        check("t37_valid_after_e3", evt_valid, 1);
        check("t37_pin", evt_pin, 5);
        check("t37_rising", evt_rising, 1);
        evt_ready = 1'b1;
        wait_neg(1);
        evt_ready = 1'b0;
        check("t37_drained", evt_valid, 0);

        // Ten spaced single-pin rises with the consumer stalled
        reset = 1'b1;
        gpio_in = '0;
        rise_en = '1;
        fall_en = '0;
        wait_neg(2);
        reset = 1'b0;
        wait_neg(6);
        pop_log.delete();
        for (int i = 0; i < 10; i++) begin
            gpio_in[t40_pins[i]] = 1'b1;
            wait_neg(2);
        end
        wait_neg(6);
        check("t40_full_valid", evt_valid, 1);
        check("t40_head_pin", evt_pin, 12);
        check("t40_overflow", overflow, 0);
        evt_ready = 1'b1;
        wait_neg(14);
        evt_ready = 1'b0;
        check("t40_drain_count", pop_log.size(), 10);
        if (pop_log.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                check($sformatf("t40_order_%0d", i), pop_log[i].pin, t40_pins[i]);
            end
        end

        // Held pend_rise on pin 7 behind a full FIFO, then a second rise
        reset = 1'b1;
        gpio_in = '0;
        wait_neg(2);
        reset = 1'b0;
        wait_neg(6);
        pop_log.delete();
        for (int p = 10; p <= 17; p++) gpio_in[p] = 1'b1;
        wait_neg(14);
        check("t41_full_head", evt_pin, 10);
        gpio_in[7] = 1'b1;
        wait_neg(6);
        check("t41_ovf_first_rise", overflow, 0);
        gpio_in[7] = 1'b0;
        wait_neg(4);
        gpio_in[7] = 1'b1;
        wait_neg(6);
        check("t41_ovf_second_rise", overflow, 1);
        rise_en = '0;
        ovf_clr = 1'b1;
        wait_neg(1);
        ovf_clr = 1'b0;
        check("t41_ovf_cleared", overflow, 0);
        evt_ready = 1'b1;
        wait_neg(14);
        evt_ready = 1'b0;
        check("t41_drain_count", pop_log.size(), 9);
        if (pop_log.size() == 9) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("t41_order_%0d", i), pop_log[i].pin, 10 + i);
            end
            check("t41_pin7_last", pop_log[8].pin, 7);
            check("t41_pin7_rising", pop_log[8].rising, 1);
        end

        // Simultaneous rises on pins 3 and 40, timed so pushes straddle wrap
        reset = 1'b1;
        gpio_in = '0;
        rise_en = '1;
        fall_en = '1;
        wait_neg(2);
        reset = 1'b0;
        evt_ready = 1'b1;
        wait_neg(4);
        pop_log.delete();
        guard = 0;
        while ((n_edges % 16) != 12 && guard < 40) begin
            wait_neg(1);
            guard++;
        end
        gpio_in[3]  = 1'b1;
        gpio_in[40] = 1'b1;
        wait_neg(8);
        gpio_in[3]  = 1'b0;
        wait_neg(8);
        check("t39_count", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            check("t39_first_pin", pop_log[0].pin, 3);
            check("t39_second_pin", pop_log[1].pin, 40);
            check("t39_consecutive", pop_log[1].cyc - pop_log[0].cyc, 1);
            check("t39_fall_pin", pop_log[2].pin, 3);
            check("t39_fall_polarity", pop_log[2].rising, 0);
`ifdef GPIO_CAPTURE_TIMESTAMP_EN
            check("t42_time_15", pop_log[0].ts, 15);
            check("t42_time_0", pop_log[1].ts, 0);
`else
            check("t42_time_off0", pop_log[0].ts, 0);
            check("t42_time_off1", pop_log[1].ts, 0);
`endif
        end

        // Reset mid-operation, then static-high pins through release
        evt_ready = 1'b0;
        gpio_in[20] = 1'b1;
        gpio_in[21] = 1'b1;
        wait_neg(6);
        check("t32_queued", evt_valid, 1);
        reset   = 1'b1;
        gpio_in = '1;
        wait_neg(1);
        check("t32_flushed", evt_valid, 0);
        wait_neg(2);
        reset = 1'b0;
        wait_neg(20);
        check("t38_no_event", evt_valid, 0);
        check("t38_overflow", overflow, 0);
        check("t38_gpio_sync", gpio_sync, {NP{1'b1}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_in_capture.md
GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

Interface
- REQ-001: Parameter NPADS, default 44, SHALL give the number of GPIO pad inputs monitored (matches OPENFRAME_IO_PADS).
- REQ-002: Parameter FIFO_DEPTH, default 8, SHALL give the event FIFO depth; it is a power of two and at least 2.
- REQ-003: Parameter TS_W, default 16, SHALL give the timestamp width.
- REQ-004: clk  input  1  single clock for all state.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: gpio_in  input  NPADS  asynchronous pad input levels (1.8V domain).
- REQ-007: rise_en  input  NPADS  per-pin rising-edge event enable.
- REQ-008: fall_en  input  NPADS  per-pin falling-edge event enable.
- REQ-009: gpio_sync  output  NPADS  synchronized pad levels.
- REQ-010: evt_valid  output  1  head of the event FIFO is valid.
- REQ-011: evt_ready  input  1  consumer accepts the head event.
- REQ-012: evt_pin  output  6  pin index of the head event.
- REQ-013: evt_rising  output  1  1 = rising edge, 0 = falling edge.
- REQ-014: evt_time  output  TS_W  timestamp of the head event.
- REQ-015: overflow  output  1  sticky lost-event flag.
- REQ-016: ovf_clr  input  1  clears overflow.

Function
- REQ-017: gpio_in SHALL pass through two flops (sync1, sync2); gpio_sync = sync2; a third flop (sync3) holds the previous sync2 value.
- REQ-018: A rising edge on pin i SHALL be sync2[i] & ~sync3[i] & rise_en[i]; a falling edge SHALL be ~sync2[i] & sync3[i] & fall_en[i].
- REQ-019: Each detected edge SHALL set a per-pin pend_rise or pend_fall bit on the next clock edge.
- REQ-020: An edge on a pin whose same-polarity pend bit is already set SHALL be dropped, and it SHALL set overflow.
- REQ-021: Each cycle the FIFO can accept, exactly one pending bit SHALL be pushed: lowest pin index first, and within a pin, rise before fall; the pushed bit clears on that edge.
- REQ-022: The FIFO can accept when count < FIFO_DEPTH, or when count == FIFO_DEPTH and evt_valid & evt_ready in the same cycle.
- REQ-023: When the FIFO is full, pending bits SHALL be held and not dropped.
- REQ-024: Timing: let E0 be the first clk edge that samples the new level into sync1. Then sync2 updates at E1, pend sets at E2, the FIFO write occurs at E3, and evt_valid is high in the cycle after E3 (for an uncontended event into an empty FIFO).
- REQ-025: The head event SHALL be removed on any edge where evt_valid & evt_ready.
- REQ-026: evt_pin, evt_rising and evt_time SHALL remain stable while evt_valid is high and evt_ready is low.
- REQ-027: evt_time SHALL be the free-running counter value at the push edge; the counter SHALL wrap from 2^TS_W-1 to 0.
- REQ-028: If ovf_clr and a new drop occur in the same cycle, overflow SHALL remain 1 (set wins).
- REQ-029: Clearing rise_en or fall_en SHALL NOT clear pend bits that are already set.

Reset
- REQ-030: While reset is high, the following SHALL be 0: sync1, sync2, sync3, all pend bits, FIFO count and pointers, the timestamp counter, evt_valid and overflow. evt_pin, evt_rising, evt_time and gpio_sync SHALL also read 0.
- REQ-031: Edge detection SHALL be suppressed for the first 3 cycles after reset deasserts (arm counter), so static-high pins do not produce spurious rising events.
- REQ-032: Reset asserted mid-operation SHALL discard all FIFO contents and pending events within one edge.

Configuration
- REQ-033: With GPIO_CAPTURE_TIMESTAMP_EN defined, the TS_W counter SHALL exist and evt_time carries timestamps as in REQ-027.
- REQ-034: Without GPIO_CAPTURE_TIMESTAMP_EN, the counter and the FIFO timestamp storage SHALL be removed and evt_time SHALL be constant 0.

Structure
- REQ-035: Package gpio_capture_pkg SHALL hold the NPADS default, the PIN_W = 6 constant, and the event record typedef (pin, rising, time).
- REQ-036: The event FIFO SHALL be a sub-module, gpio_capture_fifo, with valid/ready output, count, and simultaneous push/pop support.

Verification
- REQ-037: After reset, gpio_in = 0 -> 1 on pin 5 with rise_en[5] = 1 -> evt_valid high in the cycle after E3; evt_pin = 5 and evt_rising = 1.
- REQ-038: All pins held at 1 through reset release, with rise_en all 1s -> no event ever; overflow stays 0.
- REQ-039: Pins 3 and 40 rise in the same cycle, with evt_ready = 1 -> the pin 3 event then the pin 40 event on consecutive cycles, with evt_time differing by 1.
- REQ-040: evt_ready = 0 and 10 single-pin edges -> 8 events held, 2 pending, overflow = 0. Raising evt_ready then drains all 10 in detection order.
- REQ-041: With pin 7's pend_rise held (FIFO full), a second rising edge on pin 7 -> overflow = 1. A single-cycle ovf_clr then returns overflow to 0.
- REQ-042: Timestamp wrap with TS_W = 4: push events at counter values 15 and 0 -> evt_time reads 15 then 0.
